// File: rtl/nfc_mif_wr.sv
// NAND read-path memory interface: splits incoming NF_IF bytes into data, spare and
// ECC segments, byte-writes data/spare into the buffer RAM and forwards ECC parity.
module nfc_mif_wr #(
  parameter int DAT_WID = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               nfc_dat_en,
  input  logic               nfc_dat_dir,
  input  logic               nfc_dat_end,
  input  logic               nfc_spa_en,
  input  logic               nfc_ecc_en,
  input  logic [11:0]        nfc_blk_len,
  input  logic [3:0]         nfc_spa_len,
  input  logic [1:0]         nfc_ecc_len,
  input  logic [13:0]        nfc_trn_cnt,
  input  logic [13:0]        nfc_dat_addr,
  input  logic [13:0]        nfc_spa_addr,
  input  logic [2:0]         rng_sel,
  input  logic [7:0]         rng_dat,
  output logic               mif_rng_adv,
  input  logic               nfif_data_wr,
  input  logic [DAT_WID-1:0] nfif_data_out,
  output logic               nfif_wr_rdy,
  output logic               mif_ecc_wr,
  output logic [7:0]         mif_ecc_dat,
  output logic [12:0]        nfc_ram_addr,
  output logic               nfc_ram_cen,
  output logic [1:0]         nfc_ram_wen,
  output logic [15:0]        nfc_ram_din,
  output logic               mif_wr_done
);

  typedef enum logic [1:0] {IDLE, DAT, SPA, ECC} state_t;

  state_t      state_reg, state_next;
  logic [13:0] dat_ptr_reg, spa_ptr_reg, tot_cnt_reg;
  logic [11:0] blk_cnt_reg;
  logic        done_pend_reg;

  logic [11:0] ecc_len_dec, seg_len;
  logic        spa_on, ecc_on, start, accept, abort, seg_last, tot_last;
  logic [7:0]  in_byte, wr_byte;
  logic [13:0] wr_ptr;
  logic        unused_bits;

  assign unused_bits = ^{nfif_data_out[DAT_WID-1:8], rng_sel[1:0]};

  always_comb begin
    case (nfc_ecc_len)
      2'b01:   ecc_len_dec = 12'd18;
      2'b10:   ecc_len_dec = 12'd25;
      default: ecc_len_dec = 12'd0;
    endcase
  end

  assign spa_on   = nfc_spa_en & (nfc_spa_len != 4'd0);
  assign ecc_on   = nfc_ecc_en & (ecc_len_dec != 12'd0);
  assign start    = (state_reg == IDLE) & nfc_dat_en & ~nfc_dat_dir;
  assign accept   = nfif_data_wr & nfif_wr_rdy;
  assign abort    = nfc_dat_end & (state_reg != IDLE);
  assign tot_last = (tot_cnt_reg == nfc_trn_cnt - 14'd1);
  assign in_byte  = nfif_data_out[7:0];

  always_comb begin
    case (state_reg)
      SPA:     seg_len = {8'd0, nfc_spa_len};
      ECC:     seg_len = ecc_len_dec;
      default: seg_len = nfc_blk_len;
    endcase
  end

  assign seg_last = (blk_cnt_reg == seg_len - 12'd1);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic; transfer end takes priority over segment end
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start && nfc_trn_cnt != 14'd0) state_next = DAT;
      end
      default: begin
        if (abort) begin
          state_next = IDLE;
        end else if (accept) begin
          if (tot_last) begin
            state_next = IDLE;
          end else if (seg_last) begin
            case (state_reg)
              DAT:     state_next = spa_on ? SPA : (ecc_on ? ECC : DAT);
              SPA:     state_next = ecc_on ? ECC : DAT;
              default: state_next = DAT;
            endcase
          end
        end
      end
    endcase
  end

  // Combinational outputs
  always_comb begin
    nfif_wr_rdy = (state_reg != IDLE);
    mif_rng_adv = nfif_data_wr & nfif_wr_rdy & (state_reg == DAT) & rng_sel[2];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dat_ptr_reg <= '0;
      spa_ptr_reg <= '0;
      tot_cnt_reg <= '0;
      blk_cnt_reg <= '0;
    end else if (start) begin
      dat_ptr_reg <= nfc_dat_addr;
      spa_ptr_reg <= nfc_spa_addr;
      tot_cnt_reg <= '0;
      blk_cnt_reg <= '0;
    end else if (accept) begin
      tot_cnt_reg <= tot_cnt_reg + 14'd1;
      blk_cnt_reg <= seg_last ? 12'd0 : blk_cnt_reg + 12'd1;
      if (state_reg == DAT) dat_ptr_reg <= dat_ptr_reg + 14'd1;
      if (state_reg == SPA) spa_ptr_reg <= spa_ptr_reg + 14'd1;
    end
  end

  // Data and spare share the lane-steering path; only data is descrambled
  assign wr_ptr  = (state_reg == SPA) ? spa_ptr_reg : dat_ptr_reg;
  assign wr_byte = (state_reg == SPA) ? in_byte
                                      : (in_byte ^ (rng_sel[2] ? rng_dat : 8'h00));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nfc_ram_cen   <= 1'b1;
      nfc_ram_wen   <= 2'b11;
      nfc_ram_din   <= '0;
      nfc_ram_addr  <= '0;
      mif_ecc_wr    <= 1'b0;
      mif_ecc_dat   <= '0;
      mif_wr_done   <= 1'b0;
      done_pend_reg <= 1'b0;
    end else begin
      nfc_ram_cen   <= 1'b1;
      nfc_ram_wen   <= 2'b11;
      mif_ecc_wr    <= 1'b0;
      // Last byte's write lands first; done follows one cycle later
      done_pend_reg <= accept & tot_last & ~abort;
      mif_wr_done   <= done_pend_reg | (start & (nfc_trn_cnt == 14'd0));
      if (accept) begin
        if (state_reg == ECC) begin
          mif_ecc_wr  <= 1'b1;
          mif_ecc_dat <= in_byte;
        end else begin
          nfc_ram_addr <= wr_ptr[13:1];
          nfc_ram_cen  <= 1'b0;
          if (wr_ptr[0]) begin
            nfc_ram_wen <= 2'b01;
            nfc_ram_din <= {wr_byte, 8'h00};
          end else begin
            nfc_ram_wen <= 2'b10;
            nfc_ram_din <= {8'h00, wr_byte};
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_nfc_mif_wr.sv
// Randomised bench for nfc_mif_wr: a byte-index arithmetic model predicts RAM writes,
// ECC strobes and the done pulse, which are compared with what a negedge monitor records.
module tb_nfc_mif_wr;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        nfc_dat_en, nfc_dat_dir, nfc_dat_end, nfc_spa_en, nfc_ecc_en;
  logic [11:0] nfc_blk_len;
  logic [3:0]  nfc_spa_len;
  logic [1:0]  nfc_ecc_len;
  logic [13:0] nfc_trn_cnt, nfc_dat_addr, nfc_spa_addr;
  logic [2:0]  rng_sel;
  logic [7:0]  rng_dat;
  logic        mif_rng_adv, nfif_data_wr, nfif_wr_rdy, mif_ecc_wr, nfc_ram_cen, mif_wr_done;
  logic [15:0] nfif_data_out, nfc_ram_din;
  logic [7:0]  mif_ecc_dat;
  logic [12:0] nfc_ram_addr;
  logic [1:0]  nfc_ram_wen;

  always #5 clk = ~clk;

  nfc_mif_wr #(.DAT_WID(16)) dut (
    .clk(clk), .rst_n(rst_n), .nfc_dat_en(nfc_dat_en), .nfc_dat_dir(nfc_dat_dir),
    .nfc_dat_end(nfc_dat_end), .nfc_spa_en(nfc_spa_en), .nfc_ecc_en(nfc_ecc_en),
    .nfc_blk_len(nfc_blk_len), .nfc_spa_len(nfc_spa_len), .nfc_ecc_len(nfc_ecc_len),
    .nfc_trn_cnt(nfc_trn_cnt), .nfc_dat_addr(nfc_dat_addr), .nfc_spa_addr(nfc_spa_addr),
    .rng_sel(rng_sel), .rng_dat(rng_dat), .mif_rng_adv(mif_rng_adv),
    .nfif_data_wr(nfif_data_wr), .nfif_data_out(nfif_data_out), .nfif_wr_rdy(nfif_wr_rdy),
    .mif_ecc_wr(mif_ecc_wr), .mif_ecc_dat(mif_ecc_dat), .nfc_ram_addr(nfc_ram_addr),
    .nfc_ram_cen(nfc_ram_cen), .nfc_ram_wen(nfc_ram_wen), .nfc_ram_din(nfc_ram_din),
    .mif_wr_done(mif_wr_done)
  );

  int errs = 0, checks = 0;
  int cyc = 0, done_n = 0, done_cyc = 0, last_evt_cyc = 0;
  logic [30:0] obs_ram[$], exp_ram[$];
  logic [7:0]  obs_ecc[$], exp_ecc[$];
  bit          rng_rand = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      cyc++;
      if (!nfc_ram_cen) begin
        obs_ram.push_back({nfc_ram_addr, nfc_ram_wen, nfc_ram_din});
        last_evt_cyc = cyc;
      end
      if (mif_ecc_wr) begin
        obs_ecc.push_back(mif_ecc_dat);
        last_evt_cyc = cyc;
      end
      if (mif_wr_done) begin
        done_n++;
        done_cyc = cyc;
      end
    end
  end

  function automatic int ecc_dec(input logic [1:0] c);
    return (c == 2'b01) ? 18 : (c == 2'b10) ? 25 : 0;
  endfunction

  // Position of byte i in the codeword sequence determines its destination
  task automatic model(input int i, input logic [7:0] d, input logic [7:0] r, output bit adv);
    int b, se, ee, cw, q, rr;
    logic [13:0] p;
    logic [7:0] v;
    b  = int'(nfc_blk_len);
    se = nfc_spa_en ? int'(nfc_spa_len) : 0;
    ee = nfc_ecc_en ? ecc_dec(nfc_ecc_len) : 0;
    cw = b + se + ee;
    q  = i / cw;
    rr = i % cw;
    adv = 1'b0;
    if (rr < b + se) begin
      if (rr < b) begin
        p = 14'(int'(nfc_dat_addr) + q * b + rr);
        v = d ^ (rng_sel[2] ? r : 8'h00);
        adv = rng_sel[2];
      end else begin
        p = 14'(int'(nfc_spa_addr) + q * se + rr - b);
        v = d;
      end
      exp_ram.push_back({p[13:1], (p[0] ? 2'b01 : 2'b10), (p[0] ? {v, 8'h00} : {8'h00, v})});
    end else begin
      exp_ecc.push_back(d);
    end
  endtask

  task automatic cfg(input int b, input bit se, input int sl, input bit ee, input int el,
                     input int trn, input int da, input int sa, input int rs);
    nfc_blk_len = 12'(b); nfc_spa_en = se; nfc_spa_len = 4'(sl);
    nfc_ecc_en = ee; nfc_ecc_len = 2'(el); nfc_trn_cnt = 14'(trn);
    nfc_dat_addr = 14'(da); nfc_spa_addr = 14'(sa); rng_sel = 3'(rs);
  endtask

  task automatic start();
    nfc_dat_en = 1'b1;
    nfc_dat_dir = 1'b0;
    @(negedge clk);
    nfc_dat_en = 1'b0;
  endtask

  task automatic send(input int n, input int first, input bit b2b, input int base);
    logic [15:0] d16;
    bit adv;
    for (int k = 0; k < n; k++) begin
      if (!b2b) repeat ($urandom_range(0, 2)) begin
        nfif_data_wr = 1'b0;
        @(negedge clk);
      end
      d16 = (base >= 0) ? 16'(base + k) : 16'($urandom);
      nfif_data_wr = 1'b1;
      nfif_data_out = d16;
      if (rng_rand) rng_dat = 8'($urandom);
      model(first + k, d16[7:0], rng_dat, adv);
      #1 chk("rng_adv", mif_rng_adv, adv);
      @(negedge clk);
    end
    nfif_data_wr = 1'b0;
  endtask

  task automatic compare(input string tag, input int exp_done);
    int n;
    repeat (4) @(negedge clk);
    #1;
    chk({tag, "_nram"}, obs_ram.size(), exp_ram.size());
    n = (obs_ram.size() < exp_ram.size()) ? obs_ram.size() : exp_ram.size();
    for (int i = 0; i < n; i++) chk({tag, "_ram"}, obs_ram[i], exp_ram[i]);
    chk({tag, "_necc"}, obs_ecc.size(), exp_ecc.size());
    n = (obs_ecc.size() < exp_ecc.size()) ? obs_ecc.size() : exp_ecc.size();
    for (int i = 0; i < n; i++) chk({tag, "_ecc"}, obs_ecc[i], exp_ecc[i]);
    chk({tag, "_done"}, done_n, exp_done);
    if (exp_done == 1 && done_n == 1 && exp_ram.size() + exp_ecc.size() > 0)
      chk({tag, "_done_cyc"}, done_cyc, last_evt_cyc + 1);
    chk({tag, "_rdy"}, nfif_wr_rdy, 1'b0);
    obs_ram.delete(); exp_ram.delete(); obs_ecc.delete(); exp_ecc.delete();
    done_n = 0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_cen"}, nfc_ram_cen, 1'b1);
    chk({tag, "_wen"}, nfc_ram_wen, 2'b11);
    chk({tag, "_din"}, nfc_ram_din, 16'h0);
    chk({tag, "_addr"}, nfc_ram_addr, 13'h0);
    chk({tag, "_ecc_wr"}, mif_ecc_wr, 1'b0);
    chk({tag, "_ecc_dat"}, mif_ecc_dat, 8'h0);
    chk({tag, "_done"}, mif_wr_done, 1'b0);
    chk({tag, "_rdy"}, nfif_wr_rdy, 1'b0);
  endtask

  initial begin
    int b, se, sl, ee, el, cw, trn;
    rst_n = 1'b0;
    nfc_dat_en = 0; nfc_dat_dir = 0; nfc_dat_end = 0;
    cfg(4, 0, 0, 0, 0, 4, 0, 0, 0);
    rng_dat = 8'h00; nfif_data_wr = 1'b0; nfif_data_out = 16'h0;
    repeat (2) @(negedge clk);
    #1 chk_reset("rst0");
    @(negedge clk);
    rst_n = 1'b1;

    // Byte offered while idle must be ignored
    nfif_data_wr = 1'b1; nfif_data_out = 16'h0055;
    @(negedge clk);
    nfif_data_wr = 1'b0;
    compare("idle_wr", 0);

    cfg(4, 0, 0, 0, 0, 4, 'h10, 0, 0);
    start(); send(4, 0, 1, 'hA0); compare("t1", 1);

    cfg(2, 1, 2, 1, 1, 22, 'h20, 'h100, 0);
    start(); send(22, 0, 0, -1); compare("t2", 1);

    cfg(1, 1, 1, 0, 0, 2, 'h40, 'h200, 3'b100);
    rng_dat = 8'hFF;
    start(); send(1, 0, 1, 'h5A); send(1, 1, 1, 'h5A); compare("rng", 1);

    cfg(8, 0, 0, 0, 0, 3, 'h03, 0, 0);
    start(); send(3, 0, 1, -1); compare("odd", 1);

    cfg(8, 0, 0, 0, 0, 8, 'h30, 0, 0);
    start(); send(2, 0, 1, -1);
    nfc_dat_end = 1'b1;
    @(negedge clk);
    nfc_dat_end = 1'b0;
    #1 chk("abort_rdy", nfif_wr_rdy, 1'b0);
    compare("abort", 0);
    cfg(8, 0, 0, 0, 0, 8, 'h50, 0, 0);
    start(); send(8, 0, 0, -1); compare("restart", 1);

    cfg(4, 0, 0, 0, 0, 0, 'h60, 0, 0);
    nfc_dat_en = 1'b1;
    @(negedge clk);
    nfc_dat_en = 1'b0;
    #1 chk("zero_done", mif_wr_done, 1'b1);
    chk("zero_cen", nfc_ram_cen, 1'b1);
    @(negedge clk);
    chk("zero_done_end", mif_wr_done, 1'b0);
    compare("zero", 1);

    rng_rand = 1'b1;
    for (int it = 0; it < 10; it++) begin
      b = $urandom_range(1, 6); se = $urandom_range(0, 1); sl = $urandom_range(0, 5);
      ee = $urandom_range(0, 1); el = $urandom_range(0, 3);
      cw = b + (se ? sl : 0) + (ee ? ecc_dec(2'(el)) : 0);
      trn = $urandom_range(1, 2 * cw + 3);
      cfg(b, 1'(se), sl, 1'(ee), el, trn, int'($urandom_range(0, 16383)),
          int'($urandom_range(0, 16383)), int'($urandom_range(0, 7)));
      start(); send(trn, 0, 1'(it % 2), -1); compare($sformatf("rnd%0d", it), 1);
    end

    // Asynchronous reset mid-transfer, right after an ECC strobe has been registered
    cfg(2, 0, 0, 1, 1, 40, 'h70, 0, 0);
    start(); send(10, 0, 1, -1);
    nfif_data_wr = 1'b1; nfif_data_out = 16'h00C3;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset("rst_mid");
    nfif_data_wr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    obs_ram.delete(); exp_ram.delete(); obs_ecc.delete(); exp_ecc.delete();
    done_n = 0;
    repeat (2) @(negedge clk);
    #1 chk("post_rst_cen", nfc_ram_cen, 1'b1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/nfc_mif_wr.md
Name: nfc_mif_wr

Overview:
- NAND read-path memory interface: accepts bytes from the NF_IF write handshake and splits each codeword into data, spare and ECC segments.
- Data and spare bytes are byte-written into the NFC buffer RAM at separate addresses; ECC parity bytes are forwarded to the ECC decoder and not stored.
- Optionally descrambles data bytes with the RNG stream.
- Sits between nf_if and the RAM/ECC decoder; it is the companion of the program-path (RAM-to-NAND) interface.

Parameters:
- DAT_WID, 16, NF_IF data bus width; only bits [7:0] carry data (8-bit mode only).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- nfc_dat_en  in  1  start pulse/level from SFR
- nfc_dat_dir  in  1  0 = NAND-to-RAM (this block), 1 = ignored
- nfc_dat_end  in  1  abort; returns FSM to IDLE
- nfc_spa_en  in  1  spare segment present
- nfc_ecc_en  in  1  ECC segment present
- nfc_blk_len  in  12  data bytes per codeword
- nfc_spa_len  in  4  spare bytes per codeword
- nfc_ecc_len  in  2  ECC bytes: 00→0, 01→18, 10→25, 11→0
- nfc_trn_cnt  in  14  total bytes in transfer
- nfc_dat_addr  in  14  start byte address, data
- nfc_spa_addr  in  14  start byte address, spare
- rng_sel  in  3  bit2 = descramble enable
- rng_dat  in  8  current RNG byte
- mif_rng_adv  out  1  RNG advance strobe
- nfif_data_wr  in  1  byte valid from NF_IF
- nfif_data_out  in  DAT_WID  byte from NF_IF
- nfif_wr_rdy  out  1  block can accept a byte
- mif_ecc_wr  out  1  ECC byte strobe
- mif_ecc_dat  out  8  ECC byte
- nfc_ram_addr  out  13  RAM word address
- nfc_ram_cen  out  1  RAM chip enable, active low
- nfc_ram_wen  out  2  byte write enables, active low; [0] = low byte
- nfc_ram_din  out  16  RAM write data
- mif_wr_done  out  1  one-cycle pulse when the transfer completes

Behaviour:
- Reset values: nfc_ram_cen=1, nfc_ram_wen=2'b11, nfc_ram_din=0, nfc_ram_addr=0, mif_ecc_wr=0, mif_ecc_dat=0, mif_wr_done=0.
- Reset also clears the FSM (to IDLE) and all counters.
- Combinational outputs: nfif_wr_rdy=1 in DAT/SPA/ECC, 0 in IDLE; mif_rng_adv=accept & DAT & rng_sel[2].
- accept = nfif_data_wr & nfif_wr_rdy. nfif_data_wr while not ready is ignored.
- FSM states: IDLE, DAT, SPA, ECC.
- IDLE→DAT on nfc_dat_en & ~nfc_dat_dir. On that transition:
  - dat_ptr ← nfc_dat_addr, spa_ptr ← nfc_spa_addr;
  - blk_cnt ← 0, tot_cnt ← 0.
- If nfc_trn_cnt==0 at start: stay IDLE, pulse mif_wr_done next cycle, no writes.
- Segment lengths: DAT = nfc_blk_len; SPA = nfc_spa_len, skipped if nfc_spa_en=0 or length 0; ECC = decoded nfc_ecc_len, skipped if nfc_ecc_en=0 or length 0.
- Segment end: an accepted byte with blk_cnt==len-1. Then blk_cnt←0 and the FSM moves to the next present segment in the order DAT→SPA→ECC→DAT (next codeword).
- Transfer end: an accepted byte with tot_cnt==nfc_trn_cnt-1. The FSM goes to IDLE and mif_wr_done pulses next cycle. Transfer end overrides segment end.
- nfc_dat_end in any non-IDLE state: FSM→IDLE next cycle, no done pulse. Any byte accepted in that same cycle is still written.
- DAT accept, registered one cycle after accept:
  - byte = nfif_data_out[7:0] ^ (rng_sel[2] ? rng_dat : 0);
  - nfc_ram_addr = dat_ptr[13:1], cen=0;
  - dat_ptr[0]=0: wen=2'b10, din={8'h0,byte}; dat_ptr[0]=1: wen=2'b01, din={byte,8'h0};
  - dat_ptr increments.
- SPA accept: same as DAT using spa_ptr, with no descrambling.
- ECC accept: mif_ecc_wr=1, mif_ecc_dat=nfif_data_out[7:0], both registered; RAM idle.
- Non-accept cycles: cen=1, wen=2'b11. addr/din hold their last value.
- Pointers wrap modulo 2^14; tot_cnt and blk_cnt do not wrap within a legal transfer.
- Throughput: one byte per clock, sustained; latency from accept to RAM strobe is 1 cycle.

Test Plan:
- blk_len=4, spa/ecc off, trn_cnt=4, dat_addr=0x10, bytes A0..A3 back-to-back → RAM writes:
  - word 0x08 wen=10 din=00A0;
  - word 0x08 wen=01 din=A100;
  - word 0x09 wen=10 din=00A2;
  - word 0x09 wen=01 din=A300;
  - mif_wr_done pulses the cycle after the last write.
- blk_len=2, spa_len=2 (spa_addr=0x100), ecc_len=01, trn_cnt=22 → 2 RAM writes at data, then 2 at word 0x80, then 18 mif_ecc_wr strobes, then IDLE and done.
- rng_sel=3'b100, rng_dat=0xFF, input 0x5A in DAT → din low byte 0xA5 with mif_rng_adv high; the same setting in SPA writes 0x5A.
- Odd dat_addr=0x03, 3 bytes → lanes high/low/high at words 1,2,2.
- nfc_dat_end asserted after 2 of 8 bytes → IDLE, nfif_wr_rdy=0, no done pulse; a restart reloads pointers.
- nfc_trn_cnt=0 start → done pulse, cen stays 1; rst_n low mid-transfer → all outputs at reset values immediately.
